// File: rtl/add_sequencer.sv
// add_sequencer: two-requester round-robin sequencer (req/addrs in, ack/busy/gnt out) driving shared memory (addr/rd/wr/data) and 4-bit adder (a/b/start in, sum/cout back)
module add_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_i,
  input  logic [ADDR_W-1:0] src_a0_i,
  input  logic [ADDR_W-1:0] src_b0_i,
  input  logic [ADDR_W-1:0] dst0_i,
  input  logic [ADDR_W-1:0] src_a1_i,
  input  logic [ADDR_W-1:0] src_b1_i,
  input  logic [ADDR_W-1:0] dst1_i,
  output logic [1:0]        ack_o,
  output logic              busy_o,
  output logic              gnt_id_o,
  output logic              carry_flag_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_en_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_wr_en_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [DATA_W-1:0] add_a_o,
  output logic [DATA_W-1:0] add_b_o,
  output logic              add_start_o,
  input  logic [DATA_W-1:0] add_sum_i,
  input  logic              add_cout_i
);
  typedef enum logic [2:0] {IDLE, READ_A, READ_B, CAPT_B, ADD, WRITE, DONE} state_t;
  state_t state_q;
  logic [ADDR_W-1:0] a_q, b_q, d_q, addr_q;
  logic [DATA_W-1:0] op_a_q, op_b_q, sum_q;
  logic [1:0] ack_q;
  logic gnt_q, last_q, carry_q, rd_q, wr_q, start_q, g;
  assign g = &req_i ? ~last_q : req_i[1];
  assign ack_o = ack_q;
  assign busy_o = state_q != IDLE;
  assign gnt_id_o = gnt_q;
  assign carry_flag_o = carry_q;
  assign mem_addr_o = addr_q;
  assign mem_rd_en_o = rd_q;
  assign mem_wr_en_o = wr_q;
  assign mem_wdata_o = sum_q;
  assign add_a_o = op_a_q;
  assign add_b_o = op_b_q;
  assign add_start_o = start_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      d_q <= '0;
      addr_q <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      sum_q <= '0;
      ack_q <= '0;
      gnt_q <= 1'b0;
      last_q <= 1'b1;
      carry_q <= 1'b0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      addr_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      start_q <= 1'b0;
      ack_q <= '0;
      case (state_q)
        IDLE: if (|req_i) begin
          gnt_q <= g;
          a_q <= g ? src_a1_i : src_a0_i;
          b_q <= g ? src_b1_i : src_b0_i;
          d_q <= g ? dst1_i : dst0_i;
          addr_q <= g ? src_a1_i : src_a0_i;
          rd_q <= 1'b1;
          state_q <= READ_A;
        end
        READ_A: begin
          addr_q <= b_q;
          rd_q <= 1'b1;
          state_q <= READ_B;
        end
        READ_B: begin
          op_a_q <= mem_rdata_i;
          state_q <= CAPT_B;
        end
        CAPT_B: begin
          op_b_q <= mem_rdata_i;
          start_q <= 1'b1;
          state_q <= ADD;
        end
        ADD: begin
          sum_q <= add_sum_i;
          carry_q <= add_cout_i;
          addr_q <= d_q;
          wr_q <= 1'b1;
          state_q <= WRITE;
        end
        WRITE: begin
          ack_q <= gnt_q ? 2'b10 : 2'b01;
          state_q <= DONE;
        end
        DONE: begin
          last_q <= gnt_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_add_sequencer.sv
// tb_add_sequencer: scoreboard bench with memory/adder models around add_sequencer
module tb_add_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] req = '0, ack;
  logic [3:0] src_a0 = '0, src_b0 = '0, dst0 = '0, src_a1 = '0, src_b1 = '0, dst1 = '0;
  logic busy, gnt_id, carry_flag, mem_rd_en, mem_wr_en, add_start, add_cout;
  logic [3:0] mem_addr, mem_wdata, add_a, add_b, add_sum;
  logic [3:0] mem_rdata = '0;
  logic [3:0] mem [16];
  typedef struct {int id; logic [3:0] dst; logic [3:0] sum; logic carry;} exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0, acks = 0;
  always #5 clk = ~clk;
  add_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_i(req),
    .src_a0_i(src_a0), .src_b0_i(src_b0), .dst0_i(dst0),
    .src_a1_i(src_a1), .src_b1_i(src_b1), .dst1_i(dst1),
    .ack_o(ack), .busy_o(busy), .gnt_id_o(gnt_id), .carry_flag_o(carry_flag),
    .mem_addr_o(mem_addr), .mem_rd_en_o(mem_rd_en), .mem_rdata_i(mem_rdata),
    .mem_wr_en_o(mem_wr_en), .mem_wdata_o(mem_wdata),
    .add_a_o(add_a), .add_b_o(add_b), .add_start_o(add_start),
    .add_sum_i(add_sum), .add_cout_i(add_cout)
  );
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  exp_t e;
  always @(negedge clk) if (ack !== 2'b00) begin
    acks++;
    if (sb.size() == 0) chk("unexpected_ack", {30'd0, ack}, 0);
    else begin
      e = sb.pop_front();
      chk("ack", {30'd0, ack}, e.id == 1 ? 2 : 1);
      chk("gnt_id", {31'd0, gnt_id}, e.id);
      chk("mem_dst", {28'd0, mem[e.dst]}, {28'd0, e.sum});
      chk("carry", {31'd0, carry_flag}, {31'd0, e.carry});
    end
  end
  task automatic push(input int id, input logic [3:0] d, input logic [3:0] s, input logic c);
    exp_t x;
    x.id = id; x.dst = d; x.sum = s; x.carry = c;
    sb.push_back(x);
  endtask
  task automatic set_addr(input int id, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
    if (id == 1) begin src_a1 = a; src_b1 = b; dst1 = d; end
    else begin src_a0 = a; src_b0 = b; dst0 = d; end
  endtask
  task automatic run_op(input int id, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                        input logic [3:0] va, input logic [3:0] vb, input logic [3:0] es, input logic ec,
                        input int drop_at);
    int n = 0, bsy = 0;
    mem[a] = va;
    mem[b] = vb;
    push(id, d, es, ec);
    set_addr(id, a, b, d);
    req[id] = 1'b1;
    while (n < 20 && ack == 2'b00) begin
      @(negedge clk);
      n++;
      if (busy) bsy++;
      if (n == 1) set_addr(id, ~a, ~b, ~d);
      if (n == drop_at) req[id] = 1'b0;
    end
    req[id] = 1'b0;
    chk("latency", n, 6);
    chk("busy_cycles", bsy, 6);
    @(negedge clk);
  endtask
  task automatic rr(input int nops);
    int k = 0, cyc = 0, last = 0;
    for (int i = 0; i < nops; i++) push(i % 2, i % 2 == 1 ? 4'd9 : 4'd8, i % 2 == 1 ? 4'hC : 4'h7, 1'b0);
    req = 2'b11;
    while (k < nops && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (ack != 2'b00) begin
        chk("rr_gnt", {31'd0, gnt_id}, k % 2);
        if (k > 0) chk("ack_spacing", cyc - last, 7);
        last = cyc;
        k++;
        if (k == nops) req = 2'b00;
      end
    end
    req = 2'b00;
    if (k < nops) chk("rr_timeout", k, nops);
    @(negedge clk);
  endtask
  initial begin
    int n, a0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {ack, busy, gnt_id, carry_flag, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, add_a, add_b, add_start}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    mem[1] = 4'd3; mem[2] = 4'd4; mem[3] = 4'd6;
    set_addr(0, 4'd1, 4'd2, 4'd8);
    set_addr(1, 4'd3, 4'd3, 4'd9);
    rr(2);
    chk("carry_after_contention", {31'd0, carry_flag}, 0);
    rr(4);
    run_op(0, 4'd2, 4'd5, 4'd7, 4'd9, 4'd8, 4'd1, 1'b1, 0);
    run_op(1, 4'd4, 4'd4, 4'd4, 4'hF, 4'hF, 4'hE, 1'b1, 0);
    run_op(0, 4'd1, 4'd3, 4'd10, 4'd5, 4'hA, 4'hF, 1'b0, 2);
    mem[11] = 4'd3; mem[0] = 4'd7; mem[6] = 4'd7;
    set_addr(0, 4'd0, 4'd6, 4'd11);
    req = 2'b01;
    n = 0;
    while (n < 20 && !add_start) begin
      @(negedge clk);
      n++;
    end
    if (!add_start) chk("reach_add_timeout", n, 4);
    a0 = acks;
    rst_n = 1'b0;
    #1;
    chk("midop_reset_outs", {ack, busy, gnt_id, carry_flag, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, add_a, add_b, add_start}, 0);
    req = 2'b00;
    repeat (3) @(negedge clk);
    chk("dst_unchanged", {28'd0, mem[11]}, 3);
    chk("no_ack_after_reset", acks, a0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", {31'd0, busy}, 0);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/add_sequencer.md
# add_sequencer

Two-requester controller that owns the 4-bit adder and the shared operand memory. A granted requester supplies two source addresses and one destination address. The block reads both operands from memory, pulses the adder's `start`, writes the 4-bit sum back to the destination, latches the carry, and acknowledges. It sits between the requester logic and the existing adder/memory pair, and is the only master of the memory ports while an operation is in flight.

## Interface

Parameters:
- `ADDR_W`, 4, memory address width.
- `DATA_W`, 4, operand/sum width; must match the adder.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  2  request, one bit per requester; level, held until `ack`.
- `src_a0`, `src_b0`, `dst0`  in  ADDR_W each  requester 0 operand A, operand B and destination addresses.
- `src_a1`, `src_b1`, `dst1`  in  ADDR_W each  requester 1 addresses.
- `ack`  out  2  one-cycle completion pulse to the granted requester.
- `busy`  out  1  high in every state except IDLE.
- `gnt_id`  out  1  index of the current or most recent grant.
- `carry_flag`  out  1  carry of the most recent completed add.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_rd_en`  out  1  read strobe; data appears on `mem_rdata` one cycle later.
- `mem_rdata`  in  DATA_W  memory read data.
- `mem_wr_en`  out  1  write strobe; writes `mem_wdata` to `mem_addr` at the edge.
- `mem_wdata`  out  DATA_W  write data (the sum).
- `add_a`, `add_b`  out  DATA_W  adder operands.
- `add_start`  out  1  adder start.
- `add_sum`  in  DATA_W  adder sum, combinational from `add_a`/`add_b`/`add_start`.
- `add_cout`  in  1  adder carry.

## Operation

- States: IDLE, READ_A, READ_B, CAPT_B, ADD, WRITE, DONE.
- **IDLE**
  - If any `req` bit is high: grant, latch that requester's three addresses, and set `gnt_id`. Go to READ_A.
  - Arbitration is round-robin on `last_grant`. A single request is granted directly. When both are high, grant `!last_grant`.
  - `last_grant` resets to 1, so requester 0 wins the first contention.
- **READ_A**: `mem_rd_en`=1, `mem_addr`=latched A. Go to READ_B.
- **READ_B**: `mem_rd_en`=1, `mem_addr`=latched B. Capture `mem_rdata` into `op_a`. Go to CAPT_B.
- **CAPT_B**: capture `mem_rdata` into `op_b`. Go to ADD.
- **ADD**
  - Drive `add_start`=1, `add_a`=`op_a`, `add_b`=`op_b`.
  - Register `add_sum` into `sum_r` and `add_cout` into `carry_flag` at the exit edge.
  - Go to WRITE.
- **WRITE**: `mem_wr_en`=1, `mem_addr`=latched dst, `mem_wdata`=`sum_r`. Go to DONE.
- **DONE**: `ack[gnt_id]`=1 for exactly this cycle; update `last_grant`=`gnt_id`. Go to IDLE.
- Arithmetic: sum is {carry, sum} = A + B, modulo 2^DATA_W. For example, 9+8 gives sum 1, carry 1.
- All strobes (`mem_rd_en`, `mem_wr_en`, `add_start`, `ack`) are decoded from the state. They are 0 outside their own state.
- `add_a`/`add_b` hold `op_a`/`op_b` at all times.
- `mem_addr` is 0 when not reading or writing.

## Timing

- Reset values:
  - State IDLE.
  - `ack`=0, `busy`=0, `gnt_id`=0, `carry_flag`=0.
  - `mem_addr`=0, `mem_rd_en`=0, `mem_wr_en`=0, `mem_wdata`=0.
  - `add_a`=0, `add_b`=0, `add_start`=0.
  - Internal: `op_a`=0, `op_b`=0, `sum_r`=0, `last_grant`=1.
- Latency: with `req` sampled in IDLE at edge E0, `ack` is high in the cycle after E5 (six edges). The write commits at edge E5.
- Throughput: one operation per 7 cycles. DONE always returns to IDLE, and a pending request is granted at the next edge.
- Addresses are latched at grant. Changes to `src_*`/`dst*` after grant have no effect.
- If `req` drops mid-operation, the operation still completes and `ack` still pulses.
- Requesters must deassert `req` in the cycle after `ack`. A `req` still high in IDLE is treated as a new request.
- If the destination aliases a source, both reads complete before the write. The result uses the pre-write values.
- If `rst_n` falls mid-operation, everything returns to reset values immediately (asynchronously). No write or `ack` is issued, and the interrupted operation is lost.
- `carry_flag` changes only at the ADD exit edge. It holds its value otherwise.

## Test plan

- Single request, carry set: mem[2]=9, mem[5]=8, `req`=01 with A=2, B=5, dst=7.
  - `ack`=01 six edges later.
  - mem[7]=1, `carry_flag`=1, `busy` high for six cycles.
- Contention after reset: `req`=11, requester 0 computes 3+4 into mem[8], requester 1 computes 6+6 into mem[9].
  - Grant order is 0 then 1.
  - mem[8]=7, mem[9]=C, `carry_flag`=0 after the second `ack`.
- Round-robin: both requesters hold `req`=11 for four operations.
  - `gnt_id` sequence is 0,1,0,1.
  - `ack` pulses are 7 cycles apart.
- Aliasing: mem[4]=F, A=B=dst=4.
  - mem[4]=E, `carry_flag`=1.
- Reset mid-operation: assert `rst_n`=0 while in ADD.
  - All outputs return to 0 the same cycle.
  - Destination memory is unchanged and `ack` never pulses.
- Early `req` drop: `req` is deasserted in READ_B.
  - The operation still writes, and `ack` pulses once.
